// File: rtl/apb_ram_param.sv
// APB slave RAM with byte strobes, configurable wait states and error response.
// Memory has no reset; the control FSM and registered outputs reset asynchronously.
module apb_ram_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  input  logic                wr_protect,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NBYTES    = DATA_W / 8;
  localparam int LANE_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int MIDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic [MIDX_W-1:0]   mem_idx;
  logic                addr_err;
  logic                xfer_err;
  logic [DATA_W-1:0]   rd_val;
  logic                mem_we;

  // Address decode and error classification; the master holds the bus stable
  // for the whole transfer so nothing needs latching.
  always_comb begin
    word_idx = PADDR >> LANE_BITS;
    mem_idx  = word_idx[MIDX_W-1:0];
    addr_err = (64'(word_idx) >= 64'(DEPTH)) ||
               ((PADDR & ADDR_W'(NBYTES - 1)) != '0);
    xfer_err = addr_err || (PWRITE && wr_protect);
    rd_val   = (!PWRITE && !xfer_err) ? mem_q[mem_idx] : '0;
    mem_we   = (state_q == READY) && PSEL && PENABLE && PWRITE && !pslverr_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          if (WAIT_CYC == 0) begin
            state_d   = READY;
            pready_d  = 1'b1;
            pslverr_d = xfer_err;
            prdata_d  = rd_val;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end
        end
      end
      WAIT: begin
        // A master that drops PSEL mid-wait abandons the transfer silently.
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d   = READY;
          pready_d  = 1'b1;
          pslverr_d = xfer_err;
          prdata_d  = rd_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Writes commit on the edge that completes the transfer, lane by lane.
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (PSTRB[i]) begin
          mem_q[mem_idx][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_ram_param.md
APB_RAM_PARAM -- requirements
Module: apb_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8, range 8..64).
REQ-002 SHALL have parameter ADDR_W, default 12, byte-address width of PADDR.
REQ-003 SHALL have parameter DEPTH, default 256, number of DATA_W-bit words stored.
REQ-004 SHALL have parameter WAIT_CYC, default 0, wait states inserted per access (range 0..15).
REQ-005 SHALL have port PCLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port PSEL  input  1  slave select.
REQ-008 SHALL have port PENABLE  input  1  access-phase indicator.
REQ-009 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-010 SHALL have port PADDR  input  ADDR_W  byte address.
REQ-011 SHALL have port PWDATA  input  DATA_W  write data.
REQ-012 SHALL have port PSTRB  input  DATA_W/8  byte-lane write strobes.
REQ-013 SHALL have port wr_protect  input  1  1 = all writes rejected.
REQ-014 SHALL have port PRDATA  output  DATA_W  registered read data.
REQ-015 SHALL have port PREADY  output  1  registered transfer-complete.
REQ-016 SHALL have port PSLVERR  output  1  registered error, valid only while PREADY=1.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, READY; PREADY=1 only in READY.
REQ-018 SHALL, in IDLE on setup cycle (PSEL=1, PENABLE=0), go to READY if WAIT_CYC=0, else go to WAIT with counter = WAIT_CYC-1.
REQ-019 SHALL, in WAIT, decrement counter each cycle; go to READY on edge where counter=0 and PSEL=1.
REQ-020 SHALL leave READY for IDLE on the next edge unconditionally (one-cycle PREADY pulse; back-to-back setup accepted the cycle after).
REQ-021 SHALL, if PSEL drops while in WAIT, return to IDLE with no memory write and PREADY never asserted.
REQ-022 SHALL treat PSEL=1 with PENABLE=1 in IDLE (no setup seen) as no transfer; stay IDLE.
REQ-023 SHALL compute word index = PADDR >> log2(DATA_W/8); flag error if index >= DEPTH or PADDR low (log2(DATA_W/8)) bits nonzero.
REQ-024 SHALL flag error on write when wr_protect=1, sampled on the edge entering READY.
REQ-025 SHALL load PSLVERR on the edge entering READY; PSLVERR=0 in IDLE/WAIT.
REQ-026 SHALL, for read without error, load PRDATA with memory[index] on edge entering READY; PRDATA=0 in all other states and on error.
REQ-027 SHALL, for write without error, update only byte lanes with PSTRB[i]=1 on the edge leaving READY (PSEL=PENABLE=1); PSTRB=0 completes with no change and no error.
REQ-028 SHALL ignore PSTRB on reads.
REQ-029 SHALL perform no memory write on any error transfer.
REQ-030 SHALL have memory contents undefined after power-up and unaffected by reset.
REQ-031 SHALL sample PADDR/PWRITE/PWDATA/PSTRB as held stable by the master from setup to completion; no internal address latch required.

Reset
REQ-032 SHALL, while PRESETn=0, force FSM=IDLE, counter=0, PRDATA=0, PREADY=0, PSLVERR=0.
REQ-033 SHALL, on reset asserted mid-transfer, abandon the transfer with no memory write.
REQ-034 SHALL accept a new setup on the first rising edge after PRESETn deasserts.

Verification
REQ-035 SHALL cover: DATA_W=32, WAIT_CYC=0, write 0xDEADBEEF to 0x010 PSTRB=0xF, read 0x010 -> PREADY in first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-036 SHALL cover: write 0x11223344 PSTRB=0x5 over 0xDEADBEEF at 0x010, read -> 0xDE22BE44.
REQ-037 SHALL cover: WAIT_CYC=3, read -> exactly 3 access cycles with PREADY=0, then one with PREADY=1; PSEL drop in wait -> no PREADY, memory unchanged.
REQ-038 SHALL cover: DEPTH=256 read at 0x400, and access at 0x011 -> PREADY=1, PSLVERR=1, PRDATA=0, no write.
REQ-039 SHALL cover: wr_protect=1 write 0x0 to 0x010 -> PSLVERR=1, readback still 0xDEADBEEF; read with wr_protect=1 -> PSLVERR=0.
REQ-040 SHALL cover: PRESETn pulsed low during WAIT of a write -> outputs 0 immediately, target word unchanged, next transfer completes normally.
